// File: rtl/fu_result_buffer_if.sv
// Result entry type and the FU/CDB-side bus of fu_result_buffer.
// fu_result_buffer is the slave; the FUs and the CDB arbiter drive the master side.
`ifndef NUM_FU_TOTAL
`define NUM_FU_TOTAL 4
`endif

typedef struct packed {
  logic        valid;
  logic [5:0]  tag;
  logic [31:0] value;
} cdb_entry_t;

interface fu_result_buffer_if #(
  parameter int NUM_FU = `NUM_FU_TOTAL
);
  // Handshakes:
  // - Push side: an FU transfers fu_result[i] on a posedge when fu_result[i].valid and fu_ready[i] are both 1.
  //   fu_ready is registered-only, so an FU may decide on valid after looking at it.
  // - Pop side: the arbiter consumes fu_outputs[i] on a posedge when fu_outputs[i].valid and cdb_gnt[i] are both 1.
  //   A grant with valid=0 has no effect.
  cdb_entry_t [NUM_FU-1:0] fu_result;
  logic       [NUM_FU-1:0] fu_ready;
  logic       [NUM_FU-1:0] cdb_gnt;
  cdb_entry_t [NUM_FU-1:0] fu_outputs;

  modport master (
    output fu_result,
    output cdb_gnt,
    input  fu_ready,
    input  fu_outputs
  );

  modport slave (
    input  fu_result,
    input  cdb_gnt,
    output fu_ready,
    output fu_outputs
  );
endinterface

// File: rtl/fu_result_buffer.sv
// Per-FU result FIFOs between the functional units and the CDB arbiter.
// The head of each FIFO is that FU's CDB request; a grant pops it. DEPTH must be a power of two and at least 2.
module fu_result_buffer #(
  parameter int NUM_FU = `NUM_FU_TOTAL,
  parameter int DEPTH  = 2
) (
  input  logic               clock,
  input  logic               reset,
  fu_result_buffer_if.slave  bus,
  input  logic               flush,
  output logic               overflow_err
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  cdb_entry_t       storage_q [NUM_FU][DEPTH];
  logic [PTR_W-1:0] head_q  [NUM_FU];
  logic [PTR_W-1:0] head_d  [NUM_FU];
  logic [PTR_W-1:0] tail_q  [NUM_FU];
  logic [PTR_W-1:0] tail_d  [NUM_FU];
  logic [CNT_W-1:0] count_q [NUM_FU];
  logic [CNT_W-1:0] count_d [NUM_FU];
  logic [NUM_FU-1:0] push;
  logic [NUM_FU-1:0] pop;
  logic [NUM_FU-1:0] push_while_full;
  logic overflow_q;
  logic overflow_d;

  // Outputs decode from flops only; empty FIFOs present an all-zero entry.
  always_comb begin
    bus.fu_ready   = '0;
    bus.fu_outputs = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      bus.fu_ready[i] = (count_q[i] != FULL_CNT);
      if (count_q[i] != '0) begin
        bus.fu_outputs[i]       = storage_q[i][head_q[i]];
        bus.fu_outputs[i].valid = 1'b1;
      end
    end
  end

  always_comb begin
    push            = '0;
    pop             = '0;
    push_while_full = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      push[i]            = bus.fu_result[i].valid && (count_q[i] != FULL_CNT);
      pop[i]             = bus.cdb_gnt[i] && (count_q[i] != '0);
      push_while_full[i] = bus.fu_result[i].valid && (count_q[i] == FULL_CNT);
      head_d[i]  = head_q[i];
      tail_d[i]  = tail_q[i];
      count_d[i] = count_q[i];
      if (flush) begin
        head_d[i]  = '0;
        tail_d[i]  = '0;
        count_d[i] = '0;
      end else begin
        if (push[i]) tail_d[i] = tail_q[i] + PTR_W'(1);
        if (pop[i])  head_d[i] = head_q[i] + PTR_W'(1);
        case ({push[i], pop[i]})
          2'b10:   count_d[i] = count_q[i] + CNT_W'(1);
          2'b01:   count_d[i] = count_q[i] - CNT_W'(1);
          default: count_d[i] = count_q[i];
        endcase
      end
    end
    // A dropped push is a protocol violation by the FU, independent of any flush.
    overflow_d = overflow_q | (|push_while_full);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_FU; i++) begin
        head_q[i]  <= '0;
        tail_q[i]  <= '0;
        count_q[i] <= '0;
      end
      overflow_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        head_q[i]  <= head_d[i];
        tail_q[i]  <= tail_d[i];
        count_q[i] <= count_d[i];
      end
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: reads are masked by count.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (push[i] && !flush) storage_q[i][tail_q[i]] <= bus.fu_result[i];
    end
  end

  assign overflow_err = overflow_q;
endmodule
